// File: rtl/sha256_msg_schedule.sv
// rtl/sha256_msg_schedule.sv - SHA-256 message-schedule (W-expansion) stage
module sha256_msg_schedule #(
    parameter int NUM_ROUNDS = 64
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [511:0] block_in,
    output logic         w_valid,
    input  logic         w_ready,
    output logic [31:0]  w_out,
    output logic [5:0]   w_idx,
    output logic         w_last
);

    localparam logic [5:0] LAST_T = 6'(NUM_ROUNDS - 1);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t      state_q, state_d;
    logic [5:0]  t_q, t_d;
    logic [31:0] win_q [16];
    logic [31:0] win_d [16];
    logic [31:0] new_word;

    function automatic logic [31:0] sigma0(input logic [31:0] x);
        return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ {3'b000, x[31:3]};
    endfunction

    function automatic logic [31:0] sigma1(input logic [31:0] x);
        return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ {10'b0, x[31:10]};
    endfunction

    // W[t+16] from the current window (window[0] holds W[t]); single-cycle 4-operand add
    always_comb begin
        new_word = sigma1(win_q[14]) + win_q[9] + sigma0(win_q[1]) + win_q[0];
    end

    // State, round counter and window registers; reset abandons any block in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            t_q     <= 6'd0;
            for (int i = 0; i < 16; i++) begin
                win_q[i] <= 32'd0;
            end
        end else begin
            state_q <= state_d;
            t_q     <= t_d;
            win_q   <= win_d;
        end
    end

    // Next-state: load on input handshake, slide window on each output handshake
    always_comb begin
        state_d = state_q;
        t_d     = t_q;
        win_d   = win_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    for (int i = 0; i < 16; i++) begin
                        win_d[i] = block_in[511 - 32*i -: 32];
                    end
                    t_d     = 6'd0;
                    state_d = RUN;
                end
            end
            RUN: begin
                if (w_ready) begin
                    if (t_q == LAST_T) begin
                        t_d     = 6'd0;
                        state_d = IDLE;
                    end else begin
                        for (int i = 0; i < 15; i++) begin
                            win_d[i] = win_q[i + 1];
                        end
                        win_d[15] = new_word;
                        t_d       = t_q + 6'd1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs depend only on registered state, so w_valid never depends on w_ready
    always_comb begin
        in_ready = (state_q == IDLE);
        w_valid  = (state_q == RUN);
        w_out    = (state_q == RUN) ? win_q[0] : 32'd0;
        w_idx    = (state_q == RUN) ? t_q : 6'd0;
        w_last   = (state_q == RUN) && (t_q == LAST_T);
    end

endmodule

// File: tb/tb_sha256_msg_schedule.sv
// tb/tb_sha256_msg_schedule.sv - self-checking bench for sha256_msg_schedule
module tb_sha256_msg_schedule;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         sel;
    logic         in_valid;
    logic [511:0] block_in;
    logic         w_ready;

    logic         in_ready64, w_valid64, w_last64;
    logic [31:0]  w_out64;
    logic [5:0]   w_idx64;
    logic         in_ready20, w_valid20, w_last20;
    logic [31:0]  w_out20;
    logic [5:0]   w_idx20;

    logic         in_ready, w_valid, w_last;
    logic [31:0]  w_out;
    logic [5:0]   w_idx;

    int errors = 0;
    int checks = 0;
    int nr;
    logic [31:0] exp_w [64];
    logic [31:0] cap   [64];

    always #5 clk = ~clk;

    sha256_msg_schedule #(.NUM_ROUNDS(64)) dut64 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid & ~sel), .in_ready(in_ready64),
        .block_in(block_in), .w_valid(w_valid64), .w_ready(w_ready),
        .w_out(w_out64), .w_idx(w_idx64), .w_last(w_last64)
    );

    sha256_msg_schedule #(.NUM_ROUNDS(20)) dut20 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid & sel), .in_ready(in_ready20),
        .block_in(block_in), .w_valid(w_valid20), .w_ready(w_ready),
        .w_out(w_out20), .w_idx(w_idx20), .w_last(w_last20)
    );

    assign in_ready = sel ? in_ready20 : in_ready64;
    assign w_valid  = sel ? w_valid20  : w_valid64;
    assign w_out    = sel ? w_out20    : w_out64;
    assign w_idx    = sel ? w_idx20    : w_idx64;
    assign w_last   = sel ? w_last20   : w_last64;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    // Reference: the textbook recurrence over the full W array
    function automatic void model(input logic [511:0] blk);
        logic [31:0] s0, s1;
        for (int t = 0; t < 64; t++) begin
            if (t < 16) begin
                exp_w[t] = blk[511 - 32*t -: 32];
            end else begin
                s0 = rotr(exp_w[t-15], 7) ^ rotr(exp_w[t-15], 18) ^ (exp_w[t-15] >> 3);
                s1 = rotr(exp_w[t-2], 17) ^ rotr(exp_w[t-2], 19) ^ (exp_w[t-2] >> 10);
                exp_w[t] = s1 + exp_w[t-7] + s0 + exp_w[t-16];
            end
        end
    endfunction

    function automatic logic [511:0] rand_block();
        logic [511:0] b;
        for (int i = 0; i < 16; i++) b[32*i +: 32] = $urandom;
        return b;
    endfunction

    task automatic send_block(input logic [511:0] blk);
        int n;
        n = 0;
        while (in_ready !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("in_ready_before_load", 64'(in_ready), 64'd1);
        in_valid = 1'b1;
        block_in = blk;
        @(negedge clk);
        in_valid = 1'b0;
        block_in = rand_block();
        chk("latency_w_valid", 64'(w_valid), 64'd1);
        chk("latency_in_ready", 64'(in_ready), 64'd0);
    endtask

    // Drains words from the selected DUT; mode 1 = random w_ready
    task automatic collect(input int mode, input int stall_idx, input int pulse_idx,
                           input int stop_idx, output int count);
        int  budget;
        bit  stalled;
        count   = 0;
        budget  = 0;
        stalled = 0;
        while (1) begin
            budget++;
            if (budget > 3000) begin
                checks++;
                errors++;
                $display("FAIL collect_timeout: got %0d words expected %0d", count, nr);
                return;
            end
            if (stop_idx >= 0 && count == stop_idx) return;
            if (w_valid !== 1'b1) begin
                checks++;
                errors++;
                $display("FAIL w_valid_run: got %b expected 1 at word %0d", w_valid, count);
                return;
            end
            if (stall_idx >= 0 && !stalled && w_idx == 6'(stall_idx)) begin
                stalled = 1;
                w_ready = 1'b0;
                for (int k = 0; k < 5; k++) begin
                    @(negedge clk);
                    chk("stall_w_out", 64'(w_out), 64'(exp_w[stall_idx]));
                    chk("stall_w_idx", 64'(w_idx), 64'(stall_idx));
                    chk("stall_w_valid", 64'(w_valid), 64'd1);
                end
            end
            w_ready = (mode == 1) ? 1'($urandom_range(0, 1)) : 1'b1;
            if (pulse_idx >= 0 && w_idx == 6'(pulse_idx) && in_valid == 1'b0) begin
                in_valid = 1'b1;
                block_in = {16{32'hDEADBEEF}};
                chk("pulse_in_ready", 64'(in_ready), 64'd0);
            end else begin
                in_valid = 1'b0;
            end
            if (w_ready) begin
                chk("w_idx", 64'(w_idx), 64'(count));
                chk("w_out", 64'(w_out), 64'(exp_w[count]));
                chk("w_last", 64'(w_last), 64'(count == nr - 1));
                cap[count] = w_out;
                count++;
                if (count == nr) begin
                    @(negedge clk);
                    in_valid = 1'b0;
                    w_ready  = 1'b0;
                    return;
                end
            end
            @(negedge clk);
        end
    endtask

    task automatic chk_idle(input string name);
        chk({name, "_in_ready"}, 64'(in_ready), 64'd1);
        chk({name, "_w_valid"}, 64'(w_valid), 64'd0);
        chk({name, "_w_out"}, 64'(w_out), 64'd0);
        chk({name, "_w_last"}, 64'(w_last), 64'd0);
    endtask

    typedef struct {
        int          idx;
        logic [31:0] exp;
    } vec_t;

    localparam logic [511:0] ABC  = {32'h61626380, 448'd0, 32'h00000018};
    localparam logic [511:0] ONES = {16{32'hFFFFFFFF}};

    initial begin
        vec_t abc_tab [7];
        int   cnt;

        abc_tab[0] = '{0,  32'h61626380};
        abc_tab[1] = '{1,  32'h00000000};
        abc_tab[2] = '{14, 32'h00000000};
        abc_tab[3] = '{15, 32'h00000018};
        abc_tab[4] = '{16, 32'h61626380};
        abc_tab[5] = '{17, 32'h000F0000};
        abc_tab[6] = '{18, 32'h7DA86405};

        sel      = 1'b0;
        nr       = 64;
        in_valid = 1'b0;
        block_in = '0;
        w_ready  = 1'b0;
        rst_n    = 1'b0;
        #1;
        chk_idle("reset");
        chk("reset_w_idx", 64'(w_idx), 64'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk_idle("post_reset");

        // All-zero block, then the next block accepted the cycle in_ready appears
        model('0);
        send_block('0);
        collect(0, -1, -1, -1, cnt);
        chk("zero_count", 64'(cnt), 64'd64);
        chk_idle("gap_after_zero");

        // "abc" block with known schedule words
        model(ABC);
        send_block(ABC);
        collect(0, -1, -1, -1, cnt);
        chk("abc_count", 64'(cnt), 64'd64);
        for (int i = 0; i < 7; i++) begin
            chk($sformatf("abc_tab_w%0d", abc_tab[i].idx), 64'(cap[abc_tab[i].idx]), 64'(abc_tab[i].exp));
        end
        chk_idle("after_abc");

        // Backpressure at t=17
        send_block(ABC);
        collect(0, 17, -1, -1, cnt);
        chk("stall_count", 64'(cnt), 64'd64);

        // in_valid pulse during RUN must be ignored
        send_block(ABC);
        collect(0, -1, 10, -1, cnt);
        chk("pulse_count", 64'(cnt), 64'd64);
        for (int i = 0; i < 7; i++) begin
            chk("pulse_tab", 64'(cap[abc_tab[i].idx]), 64'(abc_tab[i].exp));
        end

        // Asynchronous reset mid-block
        send_block(ABC);
        collect(0, -1, -1, 30, cnt);
        chk("pre_reset_idx", 64'(w_idx), 64'd30);
        #2;
        rst_n = 1'b0;
        #1;
        chk_idle("mid_reset");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk_idle("after_mid_reset");
        model(ONES);
        send_block(ONES);
        collect(0, -1, -1, -1, cnt);
        chk("ones_count", 64'(cnt), 64'd64);
        chk("ones_w0", 64'(cap[0]), 64'h00000000FFFFFFFF);
        chk("ones_w16", 64'(cap[16]), 64'(exp_w[16]));

        // Random blocks with random w_ready, both round counts
        for (int s = 0; s < 2; s++) begin
            sel = (s == 1);
            nr  = (s == 1) ? 20 : 64;
            @(negedge clk);
            for (int b = 0; b < 3; b++) begin
                logic [511:0] rb;
                rb = rand_block();
                model(rb);
                send_block(rb);
                collect(1, -1, -1, -1, cnt);
                chk("rand_count", 64'(cnt), 64'(nr));
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/sha256_msg_schedule.md
Name: sha256_msg_schedule

Overview:
- SHA-256 message-schedule (W-expansion) stage.
- Accepts one 512-bit padded message block and streams W[0..63] (one 32-bit word per handshake) to the downstream compression-round core.
- Holds a 16-word sliding window and computes each new word from the lowercase sigma functions and modular adds.

Parameters:
NUM_ROUNDS, 64, number of W words emitted per block; legal range 17..64; 64 for standard SHA-256 (smaller values for test only)

Ports:
clk  in  1  system clock, all state on rising edge
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  block_in valid
in_ready  out  1  block accepted when in_valid & in_ready
block_in  in  512  message block, big-endian: W[0]=block_in[511:480], W[15]=block_in[31:0]
w_valid  out  1  w_out valid
w_ready  in  1  consumer accepts w_out when w_valid & w_ready
w_out  out  32  current schedule word W[t]
w_idx  out  6  current round index t
w_last  out  1  high with w_valid when t == NUM_ROUNDS-1

Behaviour:
- Reset (async assert, sync-released by the clock domain):
  - State = IDLE; window words 0..15 = 0; t = 0.
  - Outputs: in_ready=1, w_valid=0, w_out=0, w_idx=0, w_last=0.
  - Reset mid-block abandons the block immediately; no partial words are emitted after release.
- States:
  - IDLE: in_ready=1, w_valid=0.
    - On in_valid&in_ready: load window[i] = block_in[511-32i -: 32] for i=0..15, t=0, go to RUN.
  - RUN: in_ready=0; in_valid is ignored and block_in is not sampled. w_valid=1, w_out=window[0], w_idx=t, w_last=(t==NUM_ROUNDS-1).
    - On w_valid&w_ready with t<NUM_ROUNDS-1: window[i]=window[i+1] for i=0..14; window[15]=new; t=t+1.
    - On w_valid&w_ready with t==NUM_ROUNDS-1: go to IDLE; t=0; window is don't-care but w_out must read 0 in IDLE (gate or clear).
    - w_ready low: all state holds; w_out, w_idx, w_last stable (AXI-style, no combinational dependence of w_valid on w_ready).
- Expansion arithmetic, from the current window, where window[0]=W[t]:
  - new = sigma1(window[14]) + window[9] + sigma0(window[1]) + window[0], mod 2^32 (carries discarded).
  - This equals W[t+16].
  - sigma0(x) = ROTR7(x) ^ ROTR18(x) ^ SHR3(x).
  - sigma1(x) = ROTR17(x) ^ ROTR19(x) ^ SHR10(x).
  - Words W[0..15] pass through unchanged. Words computed for t+16 >= NUM_ROUNDS are shifted in but never emitted.
- Timing and throughput:
  - Latency: block accepted at edge N; w_valid=1 with W[0] after edge N.
  - Throughput: one word per cycle while w_ready=1.
  - After the final handshake, exactly one IDLE cycle with in_ready=1 before the next block can start. Back-to-back blocks cost NUM_ROUNDS+1 cycles each.
- Critical path: two sigma XOR trees plus a 4-operand 32-bit add. A carry-save add followed by one CPA is acceptable. No pipelining inside the add; single-cycle new-word computation is required.

Test Plan:
1. "abc" padded block: block_in = 0x61626380, then 13 zero words, then 0x00000000, 0x00000018; w_ready=1 throughout.
   -> W[0]=0x61626380; W[1..14]=0; W[15]=0x00000018; W[16]=0x61626380; W[17]=0x000F0000.
   -> 64 words total, compared to a software model; w_last only with w_idx=63.
2. All-zero block, w_ready=1 -> 64 words all 0x00000000. Then in_ready=1 for exactly one cycle before a second block can be accepted; accept it the cycle in_ready is seen.
3. Backpressure: "abc" block, drop w_ready for 5 cycles while w_idx=17.
   -> w_out held at 0x000F0000, w_idx=17, w_valid=1 throughout. Resumes with W[18] equal to the model; total word count still 64.
4. Input ignored during RUN: pulse in_valid with a different block_in at t=10 -> in_ready=0, stream unchanged versus scenario 1.
5. Reset mid-block: assert rst_n=0 asynchronously (between edges) at t=30.
   -> w_valid=0, w_out=0, in_ready=1 immediately. After release, a new all-ones block (0xFFFFFFFF x16) gives W[0]=0xFFFFFFFF and W[16] matching the model.
6. Randomised w_ready (50%) and random blocks, NUM_ROUNDS=64 and NUM_ROUNDS=20 -> every emitted word matches the reference model, w_idx is contiguous 0..NUM_ROUNDS-1, and no word is lost or duplicated.
